uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the downstream counterpart of the team's `transmitter` block.
- Recovers 8N1 frames from an asynchronous `rx` line using an oversampling system clock and mid-bit sampling.
- Holds each received byte in an output register with a valid/ack handshake, so the processor side can consume bytes at its own pace.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16: system-clock cycles per serial bit. Must be even and >= 4; an elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- ack  in  1  consumer acknowledges the held byte; clears valid.
- data  out  8  last accepted byte, LSB received first.
- valid  out  1  level; high while `data` holds an unacknowledged byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a new byte was dropped because valid was still high.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; counters=0.
  - Synchronizer flops=1.
  - data=0x00, valid=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame with no pulses.
- Input path: `rx` passes through a 2-flop synchronizer giving rx_s. All decisions below use rx_s.
- State machine:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample rx_s:
    - 0 -> DATA, with cnt=0 and bit_idx=0.
    - 1 -> glitch; return to IDLE with no pulses.
  - DATA: at cnt==CLKS_PER_BIT-1, load rx_s into shift bit bit_idx (LSB first), cnt=0, bit_idx++. After bit_idx 7 is sampled -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> accept the byte, go to IDLE. IDLE is entered at mid-stop-bit, so back-to-back frames and the transmitter's 2-bit stop are both handled.
    - 0 -> frame_err pulse, byte discarded, go to BRK.
  - BRK: hold until rx_s==1, then IDLE. A line held low never retriggers START.
- Accept, registered on the cycle after the stop sample:
  - valid==0, or ack==1 the same cycle: data<=byte, valid<=1, no overrun.
  - valid==1 and ack==0: data unchanged, valid stays 1, overrun pulses for 1 cycle.
- Handshake: ack with valid==1 clears valid on the next edge unless an accept occurs in the same cycle. ack with valid==0 is ignored.
- Latency: valid rises N = CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles after the first clk edge at which pin `rx` is low (N=155 at default). The bench accepts N±1 to allow for synchronizer phase.
- Width rules:
  - cnt is $clog2(CLKS_PER_BIT) bits and never wraps past CLKS_PER_BIT-1.
  - bit_idx is 3 bits.
- frame_err and overrun never assert together, because the two events are mutually exclusive per frame.

Decomposition:
- Shared package uart_pkg:
  - rx state encoding IDLE/START/DATA/STOP/BRK (3 bits).
  - DATA_BITS=8.
  - Line idle level constant.
  - The `transmitter` state constants move into this package too.
- One sub-module: rx_sync, a 2-flop synchronizer with reset value 1.

Test Plan:
1. Byte 0xA5 at CLKS_PER_BIT=16, ack held 0 -> valid rises at cycle 155±1; data=0xA5; frame_err=0; overrun=0.
2. 0x3C then 0xC3 back-to-back, each with 1 stop bit; ack pulsed 1 cycle after each valid -> two accepts, data=0x3C then 0xC3, no overrun.
3. Glitch: rx low for 5 cycles then high -> START aborts at the half-bit sample; valid, frame_err and overrun stay 0; the next real frame 0x55 is received correctly.
4. Frame 0x81 with stop bit forced low, rx then held low 100 cycles -> single frame_err pulse; valid stays 0; no new START until rx returns high; a following 0x7E is received.
5. Receive 0x11 with no ack, then 0x22 -> overrun pulses once; data stays 0x11; after ack, valid=0; a third byte 0x33 gives data=0x33.
6. rst_n low for 1 cycle mid-way through DATA bits of 0xFF -> all outputs 0 next cycle; no valid for that frame; a fresh 0x0F after reset is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame width and FSM state encodings
// for both the receiver and the transmitter.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BRK   = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// level so a reset never looks like a start bit.
module rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= LINE_IDLE;
      o_sync <= LINE_IDLE;
    end else begin
      r_meta <= i_async;
      o_sync <= r_meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling on an oversampled clock, byte held in an
// output register with a valid/ack handshake, framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  generate
    if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_receiver: CLKS_PER_BIT must be even and >= 4");
    end
  endgenerate

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_acc_pend;

  rx_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_acc_pend <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      r_acc_pend <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_rx_s != LINE_IDLE) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is gone by its midpoint is treated as a glitch.
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= (w_rx_s == LINE_IDLE) ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop lets a back-to-back start edge be seen.
          if (r_cnt == FULL_LAST) begin
            r_cnt <= '0;
            if (w_rx_s == LINE_IDLE) begin
              r_acc_pend <= 1'b1;
              r_state    <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= RX_BRK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_BRK: begin
          if (w_rx_s == LINE_IDLE) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase

      // An ack in the same cycle frees the holding register for the new byte.
      if (r_acc_pend) begin
        if (!valid || ack) begin
          data  <= r_shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: drives serial frames and compares the
// handshake outputs against a frame-level model of valid/data/error events.
module tb_uart_receiver;

  localparam int C = 16;
  localparam int N = C/2 + 9*C + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed events, counted on the falling edge.
  int   n_rise = 0, n_fe = 0, n_ov = 0, n_both = 0;
  int   lat = 0;
  int   t_start = 0;
  logic pv = 1'b0;

  always @(negedge clk) begin
    if (valid && !pv) begin
      n_rise++;
      lat = cyc - t_start;
    end
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (frame_err && overrun) n_both++;
    pv = valid;
  end

  // Frame-level reference model.
  int         exp_rise = 0, exp_fe = 0, exp_ov = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_rose;

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    m_rose = 1'b0;
    if (!stop_ok) exp_fe++;
    else if (m_valid) exp_ov++;
    else begin
      m_valid = 1'b1;
      m_data  = b;
      exp_rise++;
      m_rose  = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_rise"}, n_rise, exp_rise);
    chk({tag, "_ferr"}, n_fe, exp_fe);
    chk({tag, "_ovr"}, n_ov, exp_ov);
    chk({tag, "_data"}, data, m_data);
    chk({tag, "_valid"}, valid, m_valid);
    if (m_rose) chk({tag, "_lat_ok"}, int'(lat >= N-1 && lat <= N+1), 1);
    m_rose = 1'b0;
  endtask

  // Called at a rising edge; returns at a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int idle);
    #1 rx = 1'b0;
    t_start = cyc + 1;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (C) @(posedge clk);
    end
    #1 rx = stop_ok;
    repeat (C) @(posedge clk);
    if (idle > 0) begin
      #1 rx = 1'b1;
      repeat (idle) @(posedge clk);
    end
  endtask

  task automatic ack_pulse();
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    @(posedge clk);
    m_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit         ok;

    rst_n = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single byte, no ack
    send_frame(8'hA5, 1'b1, 10); model_frame(8'hA5, 1'b1); check_frame("t1");
    ack_pulse();

    // 2: back-to-back frames, ack one cycle after each valid
    fork
      begin
        send_frame(8'h3C, 1'b1, 0); model_frame(8'h3C, 1'b1); m_valid = 1'b0; check_frame("t2a");
        send_frame(8'hC3, 1'b1, 10); model_frame(8'hC3, 1'b1); m_valid = 1'b0; check_frame("t2b");
      end
      begin
        for (int f = 0; f < 2; f++) begin
          int w = 0;
          while (!valid && w < 400) begin @(negedge clk); w++; end
          chk("t2_vwait", int'(w < 400), 1);
          @(posedge clk);
          #1 ack = 1'b1;
          @(posedge clk);
          #1 ack = 1'b0;
        end
      end
    join

    // 3: start glitch, then a real frame
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    check_frame("t3g");
    send_frame(8'h55, 1'b1, 10); model_frame(8'h55, 1'b1); check_frame("t3");
    ack_pulse();

    // 4: low stop bit followed by a held-low line
    send_frame(8'h81, 1'b0, 0); model_frame(8'h81, 1'b0);
    repeat (100) @(posedge clk);
    check_frame("t4brk");
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    check_frame("t4idle");
    send_frame(8'h7E, 1'b1, 10); model_frame(8'h7E, 1'b1); check_frame("t4");
    ack_pulse();

    // 5: overrun, then ack, then a fresh byte
    send_frame(8'h11, 1'b1, 10); model_frame(8'h11, 1'b1); check_frame("t5a");
    send_frame(8'h22, 1'b1, 10); model_frame(8'h22, 1'b1); check_frame("t5b");
    ack_pulse();
    chk("t5_ack_valid", valid, 0);
    send_frame(8'h33, 1'b1, 10); model_frame(8'h33, 1'b1); check_frame("t5c");

    // 6: reset in the middle of the data bits
    fork
      send_frame(8'hFF, 1'b1, 20);
      begin
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("t6_data", data, 8'h00);
        chk("t6_valid", valid, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_ovr", overrun, 0);
        rst_n = 1'b1;
      end
    join
    m_valid = 1'b0; m_data = 8'h00;
    check_frame("t6abort");
    send_frame(8'h0F, 1'b1, 10); model_frame(8'h0F, 1'b1); check_frame("t6");

    // Random frames, random acks, occasional bad stop bits
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) ack_pulse();
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, int'($urandom_range(2, 40)));
      model_frame(b, ok);
      check_frame($sformatf("rnd%0d", k));
    end

    chk("excl", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
